// File: rtl/fd4_fdm_pkg.sv
// Shared constants for the fd4_fdm flop banks.
package fd4_fdm_pkg;

    localparam int unsigned MAX_WIDTH  = 32;
    localparam logic        RESET_VAL  = 1'b0;
    localparam logic        PRESET_VAL = 1'b1;

endpackage

// File: rtl/fd4_cell.sv
// Single-bit rising-edge flop with asynchronous active-low reset (dominant)
// and asynchronous active-low preset.
module fd4_cell
    import fd4_fdm_pkg::*;
(
    input  logic ck,
    input  logic n_reset,
    input  logic n_set,
    input  logic d,
    output logic q_c
);

    logic q_r;

    always_ff @(posedge ck or negedge n_reset or negedge n_set) begin
        if (!n_reset) begin
            q_r <= RESET_VAL;
        end else if (!n_set) begin
            q_r <= PRESET_VAL;
        end else begin
            q_r <= d;
        end
    end

    // Level override so a preset still held when reset lifts shows at once.
    always_comb begin
        q_c = q_r;
        if (!n_reset) begin
            q_c = RESET_VAL;
        end else if (!n_set) begin
            q_c = PRESET_VAL;
        end
    end

endmodule

// File: rtl/fd4_fdm.sv
// Two WIDTH-lane flop banks: FD4 (async reset + per-lane preset) and FDM (plain).
// Define FD4_FDM_NQ_EN to add the inverted outputs FD4_nQ / FDM_nQ.
module fd4_fdm
    import fd4_fdm_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             CK,
    input  logic             nRESET,
    input  logic [WIDTH-1:0] FD4_D,
    input  logic [WIDTH-1:0] FD4_nSET,
    output logic [WIDTH-1:0] FD4_Q,
    input  logic [WIDTH-1:0] FDM_D,
`ifdef FD4_FDM_NQ_EN
    output logic [WIDTH-1:0] FDM_Q,
    output logic [WIDTH-1:0] FD4_nQ,
    output logic [WIDTH-1:0] FDM_nQ
`else
    output logic [WIDTH-1:0] FDM_Q
`endif
);

    logic [WIDTH-1:0] fdm_q = '0;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fd4
        fd4_cell u_cell (
            .ck      (CK),
            .n_reset (nRESET),
            .n_set   (FD4_nSET[i]),
            .d       (FD4_D[i]),
            .q_c     (FD4_Q[i])
        );
    end

    // FDM bank has no reset; it only ever changes on CK.
    always_ff @(posedge CK) begin
        fdm_q <= FDM_D;
    end

    assign FDM_Q = fdm_q;

`ifdef FD4_FDM_NQ_EN
    assign FD4_nQ = ~FD4_Q;
    assign FDM_nQ = ~fdm_q;
`endif

endmodule

// File: tb/tb_fd4_fdm.sv
// Scoreboard bench for fd4_fdm (WIDTH=8): directed async cases plus random cycles.
module tb_fd4_fdm;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         n_reset;
    logic [W-1:0] fd4_d, fd4_nset, fdm_d;
    logic [W-1:0] fd4_q, fdm_q;
`ifdef FD4_FDM_NQ_EN
    logic [W-1:0] fd4_nq, fdm_nq;
`endif

    always #5 clk = ~clk;

    fd4_fdm #(.WIDTH(W)) dut (
        .CK       (clk),
        .nRESET   (n_reset),
        .FD4_D    (fd4_d),
        .FD4_nSET (fd4_nset),
        .FD4_Q    (fd4_q),
        .FDM_D    (fdm_d),
`ifdef FD4_FDM_NQ_EN
        .FDM_Q    (fdm_q),
        .FD4_nQ   (fd4_nq),
        .FDM_nQ   (fdm_nq)
`else
        .FDM_Q    (fdm_q)
`endif
    );

    typedef struct {
        string        name;
        logic [W-1:0] fd4;
        logic [W-1:0] fdm;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   checks   = 0;
    int   failures = 0;

    // Reference state: forced lanes follow the force level, others hold.
    logic [W-1:0] m_fd4 = '0;
    logic [W-1:0] m_fdm = '0;

    function automatic void model_async();
        for (int i = 0; i < int'(W); i++) begin
            if (!n_reset)          m_fd4[i] = 1'b0;
            else if (!fd4_nset[i]) m_fd4[i] = 1'b1;
        end
    endfunction

    function automatic void model_clock();
        for (int i = 0; i < int'(W); i++) begin
            if (n_reset && fd4_nset[i]) m_fd4[i] = fd4_d[i];
        end
        model_async();
        m_fdm = fdm_d;
    endfunction

    always @(posedge clk) model_clock();

    task automatic expect_now(input string name);
        exp_t e;
        model_async();
        e.name = name;
        e.fd4  = m_fd4;
        e.fdm  = m_fdm;
        exp_q.push_back(e);
        -> chk_ev;
        #2;
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        #1;
        expect_now(name);
    endtask

    function automatic void check_val(input string name, input string what,
                                      input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
        end
    endfunction

    // Monitor: compares the DUT against each queued expectation once settled.
    initial begin
        forever begin
            exp_t e;
            @(chk_ev);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val(e.name, "FD4_Q", fd4_q, e.fd4);
                check_val(e.name, "FDM_Q", fdm_q, e.fdm);
`ifdef FD4_FDM_NQ_EN
                check_val(e.name, "FD4_nQ", fd4_nq, ~e.fd4);
                check_val(e.name, "FDM_nQ", fdm_nq, ~e.fdm);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_reset  = 1'b0;
        fd4_d    = '0;
        fd4_nset = '1;
        fdm_d    = '0;
        #1;
        expect_now("reset_state");

        // Reset pulse mid-cycle with D=1
        @(negedge clk); n_reset = 1'b1; fd4_d = '1;
        expect_now("rst_release_hold");
        tick("d_capture");
        @(negedge clk); n_reset = 1'b0;
        expect_now("async_reset");
        tick("reset_held");
        @(negedge clk); n_reset = 1'b1;
        expect_now("reset_release_hold");
        tick("after_reset_release");

        // Preset with D=0
        @(negedge clk); fd4_d = '0;
        tick("d_zero");
        @(negedge clk); fd4_nset = '0;
        expect_now("async_preset");
        tick("preset_held");
        @(negedge clk); fd4_nset = '1;
        expect_now("preset_release_hold");
        tick("after_preset_release");

        // Reset and preset together; reset wins, then preset shows on reset release
        @(negedge clk); n_reset = 1'b0; fd4_nset = '0;
        expect_now("reset_beats_preset");
        @(negedge clk); n_reset = 1'b1;
        expect_now("preset_after_reset_release");
        tick("preset_still_held");
        @(negedge clk); fd4_nset = '1;
        expect_now("preset_release_hold2");
        tick("after_both_release");

        // FDM sequence 1,0,1 and reset immunity
        @(negedge clk); fdm_d = '1;
        tick("fdm_1");
        @(negedge clk); fdm_d = '0;
        tick("fdm_0");
        @(negedge clk); fdm_d = '1;
        tick("fdm_1b");
        @(negedge clk); n_reset = 1'b0;
        expect_now("fdm_ignores_reset");
        @(negedge clk); fdm_d = 8'h3C;
        tick("fdm_clocks_during_reset");
        @(negedge clk); n_reset = 1'b1;
        tick("fdm_reset_release");

        // Per-lane preset: lane 0 held
        @(negedge clk); fd4_d = '0;
        tick("lane_clear");
        @(negedge clk); fd4_nset = 8'hFE;
        expect_now("lane0_preset");
        @(negedge clk); fd4_d = 8'hA5;
        tick("lane_a5");
        @(negedge clk); fd4_d = 8'hA4;
        tick("lane0_held");
        @(negedge clk); fd4_nset = '1;
        tick("lane_release");

        // Random cycles: async controls change once per cycle, at the falling edge
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n_reset  = ($urandom_range(7) != 0);
            fd4_nset = ~W'($urandom & $urandom & $urandom);
            fd4_d    = W'($urandom);
            fdm_d    = W'($urandom);
            expect_now("rand_async");
            tick("rand_edge");
        end

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
